// File: rtl/vit_3by4_dec_types.sv
// Shared types for the 3/4 Viterbi decoder output path.
// The counter/tag typedefs describe the default decoder configuration;
// parameterised blocks derive their own widths locally.
package vit_3by4_dec_types;

   localparam int cSYM_BITS  = 3;
   localparam int cTAG_W     = 4;
   localparam int cERR_CNT_W = 16;
   localparam int cBIT_CNT_W = 16;

   // one trellis decision: three decoded bits, bit0 oldest
   typedef logic [cSYM_BITS-1:0] trel_decision_t;

   // framing flags of an output word
   typedef struct packed {
      logic sop;
      logic val;
      logic eop;
   } boutputs_t;

   typedef logic [cTAG_W-1:0]     tag_t;
   typedef logic [cERR_CNT_W-1:0] errcnt_t;
   typedef logic [cBIT_CNT_W-1:0] bitcnt_t;

endpackage

// File: rtl/vit_sat_acc.sv
// Generic saturating accumulator with synchronous clear.
// osum_d is the value the register takes on the next enabled edge, so a
// caller can present the total that includes the current addend.
module vit_sat_acc #(
   parameter int pW    = 16,
   parameter int pIN_W = 2
) (
   input  logic             iclk,
   input  logic             ireset_n,
   input  logic             iclkena,
   input  logic             iclr,
   input  logic             iadd_en,
   input  logic [pIN_W-1:0] iadd,
   output logic [pW-1:0]    osum_d,
   output logic [pW-1:0]    osum_q
);

   logic [pW-1:0] sum_q;
   logic [pW:0]   base;
   logic [pW:0]   sum;

   // next sum: optional clear, then add with clamp to all-ones
   always_comb begin
      // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
      base   = iclr ? '0 : {1'b0, sum_q};
      sum    = base + (pW+1)'(iadd);
      osum_d = base[pW-1:0];
      if (iadd_en) begin
         osum_d = sum[pW] ? '1 : sum[pW-1:0];
      end
   end

   // accumulator register
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         sum_q <= '0;
      end else if (iclkena) begin
         // NOTE: sequential state uses non-blocking assignment so all flops sample the same pre-edge values.
         sum_q <= osum_d;
      end
   end

   assign osum_q = sum_q;

endmodule

// File: rtl/vit_3by4_dec_bitpack.sv
// Output stage of the 3/4 Viterbi decoder: packs 3-bit decisions LSB-first
// into pDAT_W-bit words, zero-pads the last word of a frame and returns the
// frame decoded-bit / corrected-bit totals with the eop word.
// Optional feature macro: VIT_3BY4_BITPACK_ERRCNT_EN builds the corrected-bit
// accumulator; without it ibiterr is ignored and oerrcnt stays 0.
module vit_3by4_dec_bitpack
   import vit_3by4_dec_types::*;
#(
   parameter int pDAT_W     = 8,
   parameter int pTAG_W     = 4,
   parameter int pERR_CNT_W = 16,
   parameter int pBIT_CNT_W = 16
) (
   input  logic                         iclk,
   input  logic                         ireset_n,
   input  logic                         iclkena,
   input  logic                         isop,
   input  logic                         ival,
   input  logic                         ieop,
   input  logic [pTAG_W-1:0]            itag,
   input  trel_decision_t               idat,
   input  logic [1:0]                   ibiterr,
   output logic                         osop,
   output logic                         oval,
   output logic                         oeop,
   output logic [pTAG_W-1:0]            otag,
   output logic [pDAT_W-1:0]            odat,
   output logic [$clog2(pDAT_W+1)-1:0]  onum,
   output logic [pBIT_CNT_W-1:0]        obitcnt,
   output logic [pERR_CNT_W-1:0]        oerrcnt
);

   localparam int cACC_W = pDAT_W + 2;
   localparam int cCNT_W = $clog2(pDAT_W + 3);
   localparam int cNUM_W = $clog2(pDAT_W + 1);

   typedef logic [cACC_W-1:0] acc_t;
   typedef enum logic {cRUN, cTAIL} state_t;

   // state registers
   state_t                  state_q,     state_d;
   acc_t                    acc_q,       acc_d;
   logic [cCNT_W-1:0]       cnt_q,       cnt_d;
   logic                    in_frame_q,  in_frame_d;
   logic                    first_q,     first_d;
   logic [pTAG_W-1:0]       tag_q,       tag_d;
   logic [pDAT_W-1:0]       tail_q,      tail_d;
   logic [cNUM_W-1:0]       tail_num_q,  tail_num_d;
   logic [pTAG_W-1:0]       tail_tag_q,  tail_tag_d;
   logic                    tail_sop_q,  tail_sop_d;
   logic [pBIT_CNT_W-1:0]   tail_bit_q,  tail_bit_d;
   logic [pERR_CNT_W-1:0]   tail_err_q,  tail_err_d;
   boutputs_t               out_q,       out_d;
   logic [pDAT_W-1:0]       odat_q,      odat_d;
   logic [cNUM_W-1:0]       onum_q,      onum_d;
   logic [pTAG_W-1:0]       otag_q,      otag_d;
   logic [pBIT_CNT_W-1:0]   obitcnt_q,   obitcnt_d;
   logic [pERR_CNT_W-1:0]   oerrcnt_q,   oerrcnt_d;

   // append datapath
   logic                    accept;
   acc_t                    base_acc;
   logic [cCNT_W-1:0]       base_cnt;
   logic                    base_first;
   logic [pTAG_W-1:0]       cur_tag;
   acc_t                    new_acc;
   logic [cCNT_W-1:0]       new_cnt;
   logic                    full;
   acc_t                    rem_acc;
   logic [cCNT_W-1:0]       rem_cnt;

   // frame totals including the current symbol
   logic [pBIT_CNT_W-1:0]   bitcnt_d;
   logic [pBIT_CNT_W-1:0]   bitcnt_q;
   logic [pERR_CNT_W-1:0]   errcnt_d;

   // symbols before the first sop after reset (or after an eop) are dropped
   assign accept = ival & (isop | in_frame_q);

   vit_sat_acc #(
      .pW    (pBIT_CNT_W),
      .pIN_W (2)
   ) u_bitcnt (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (iclkena),
      .iclr     (accept & isop),
      .iadd_en  (accept),
      .iadd     (2'd3),
      .osum_d   (bitcnt_d),
      .osum_q   (bitcnt_q)
   );

`ifdef VIT_3BY4_BITPACK_ERRCNT_EN
   logic [pERR_CNT_W-1:0] errcnt_q;

   vit_sat_acc #(
      .pW    (pERR_CNT_W),
      .pIN_W (2)
   ) u_errcnt (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (iclkena),
      .iclr     (accept & isop),
      .iadd_en  (accept),
      .iadd     (ibiterr),
      .osum_d   (errcnt_d),
      .osum_q   (errcnt_q)
   );
`else
   logic unused_biterr;
   assign unused_biterr = ^ibiterr;
   assign errcnt_d      = '0;
`endif

   // packing FSM: next state, accumulator update and output word selection
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      in_frame_d = in_frame_q;
      first_d    = first_q;
      tag_d      = tag_q;
      tail_d     = tail_q;
      tail_num_d = tail_num_q;
      tail_tag_d = tail_tag_q;
      tail_sop_d = tail_sop_q;
      tail_bit_d = tail_bit_q;
      tail_err_d = tail_err_q;
      out_d      = '0;
      odat_d     = odat_q;
      onum_d     = onum_q;
      otag_d     = otag_q;
      obitcnt_d  = obitcnt_q;
      oerrcnt_d  = oerrcnt_q;

      // sop restarts the frame: stale remainder is discarded
      base_acc   = isop ? '0 : acc_q;
      base_cnt   = isop ? '0 : cnt_q;
      base_first = isop | first_q;
      cur_tag    = isop ? itag : tag_q;
      new_acc    = base_acc | (acc_t'(idat) << base_cnt);
      new_cnt    = base_cnt + cCNT_W'(3);
      full       = (new_cnt >= cCNT_W'(pDAT_W));
      rem_acc    = new_acc >> pDAT_W;
      rem_cnt    = new_cnt - cCNT_W'(pDAT_W);

      // the pending padded word always leaves in the cycle after it was parked
      if (state_q == cTAIL) begin
         state_d   = cRUN;
         out_d.val = 1'b1;
         out_d.sop = tail_sop_q;
         out_d.eop = 1'b1;
         odat_d    = tail_q;
         onum_d    = tail_num_q;
         otag_d    = tail_tag_q;
         obitcnt_d = tail_bit_q;
         oerrcnt_d = tail_err_q;
      end

      if (accept) begin
         first_d = base_first;
         if (isop) begin
            tag_d      = itag;
            in_frame_d = 1'b1;
         end

         if (full) begin
            // a complete word: emit it, keep the 0..2 overflow bits at position 0
            out_d.val = 1'b1;
            out_d.sop = base_first;
            odat_d    = new_acc[pDAT_W-1:0];
            onum_d    = cNUM_W'(pDAT_W);
            otag_d    = cur_tag;
            first_d   = 1'b0;
            acc_d     = rem_acc;
            cnt_d     = rem_cnt;
            if (ieop) begin
               acc_d      = '0;
               cnt_d      = '0;
               in_frame_d = 1'b0;
               if (rem_cnt == '0) begin
                  out_d.eop = 1'b1;
                  obitcnt_d = bitcnt_d;
                  oerrcnt_d = errcnt_d;
               end else begin
                  // overflow bits become a padded word sent next cycle
                  state_d    = cTAIL;
                  tail_d     = rem_acc[pDAT_W-1:0];
                  tail_num_d = cNUM_W'(rem_cnt);
                  tail_tag_d = cur_tag;
                  tail_sop_d = 1'b0;
                  tail_bit_d = bitcnt_d;
                  tail_err_d = errcnt_d;
               end
            end
         end else if (ieop) begin
            // short last word: padded with the zeros already above cnt
            acc_d      = '0;
            cnt_d      = '0;
            in_frame_d = 1'b0;
            first_d    = 1'b0;
            if (state_q == cTAIL) begin
               // output slot is taken by the previous frame's tail; park this word
               state_d    = cTAIL;
               tail_d     = new_acc[pDAT_W-1:0];
               tail_num_d = cNUM_W'(new_cnt);
               tail_tag_d = cur_tag;
               tail_sop_d = base_first;
               tail_bit_d = bitcnt_d;
               tail_err_d = errcnt_d;
            end else begin
               out_d.val = 1'b1;
               out_d.sop = base_first;
               out_d.eop = 1'b1;
               odat_d    = new_acc[pDAT_W-1:0];
               onum_d    = cNUM_W'(new_cnt);
               otag_d    = cur_tag;
               obitcnt_d = bitcnt_d;
               oerrcnt_d = errcnt_d;
            end
         end else begin
            acc_d = new_acc;
            cnt_d = new_cnt;
         end
      end
   end

   // all state registers; reset drops any partial word and the tail
   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state_q    <= cRUN;
         acc_q      <= '0;
         cnt_q      <= '0;
         in_frame_q <= 1'b0;
         first_q    <= 1'b0;
         tag_q      <= '0;
         tail_q     <= '0;
         tail_num_q <= '0;
         tail_tag_q <= '0;
         tail_sop_q <= 1'b0;
         tail_bit_q <= '0;
         tail_err_q <= '0;
         out_q      <= '0;
         odat_q     <= '0;
         onum_q     <= '0;
         otag_q     <= '0;
         obitcnt_q  <= '0;
         oerrcnt_q  <= '0;
      end else if (iclkena) begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         in_frame_q <= in_frame_d;
         first_q    <= first_d;
         tag_q      <= tag_d;
         tail_q     <= tail_d;
         tail_num_q <= tail_num_d;
         tail_tag_q <= tail_tag_d;
         tail_sop_q <= tail_sop_d;
         tail_bit_q <= tail_bit_d;
         tail_err_q <= tail_err_d;
         out_q      <= out_d;
         odat_q     <= odat_d;
         onum_q     <= onum_d;
         otag_q     <= otag_d;
         obitcnt_q  <= obitcnt_d;
         oerrcnt_q  <= oerrcnt_d;
      end
   end

   assign osop    = out_q.sop;
   assign oval    = out_q.val;
   assign oeop    = out_q.eop;
   assign odat    = odat_q;
   assign onum    = onum_q;
   assign otag    = otag_q;
   assign obitcnt = obitcnt_q;
   assign oerrcnt = oerrcnt_q;

endmodule

// File: tb/tb_vit_3by4_dec_bitpack.sv
// Self-checking bench for vit_3by4_dec_bitpack (pDAT_W=8, pERR_CNT_W=4).
// Expected words come from a bit-level frame model pushed at drive time.
module tb_vit_3by4_dec_bitpack;

   localparam int DW   = 8;
   localparam int TW   = 4;
   localparam int EW   = 4;
   localparam int BW   = 16;
   localparam int NW   = $clog2(DW+1);
   localparam int EMAX = (1 << EW) - 1;
   localparam int BMAX = (1 << BW) - 1;

   logic          iclk = 1'b0;
   logic          ireset_n;
   logic          iclkena;
   logic          isop;
   logic          ival;
   logic          ieop;
   logic [TW-1:0] itag;
   logic [2:0]    idat;
   logic [1:0]    ibiterr;
   logic          osop;
   logic          oval;
   logic          oeop;
   logic [TW-1:0] otag;
   logic [DW-1:0] odat;
   logic [NW-1:0] onum;
   logic [BW-1:0] obitcnt;
   logic [EW-1:0] oerrcnt;

   always #5 iclk = ~iclk;

   vit_3by4_dec_bitpack #(
      .pDAT_W     (DW),
      .pTAG_W     (TW),
      .pERR_CNT_W (EW),
      .pBIT_CNT_W (BW)
   ) dut (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .iclkena  (iclkena),
      .isop     (isop),
      .ival     (ival),
      .ieop     (ieop),
      .itag     (itag),
      .idat     (idat),
      .ibiterr  (ibiterr),
      .osop     (osop),
      .oval     (oval),
      .oeop     (oeop),
      .otag     (otag),
      .odat     (odat),
      .onum     (onum),
      .obitcnt  (obitcnt),
      .oerrcnt  (oerrcnt)
   );

   typedef struct {
      bit            sop;
      bit            eop;
      logic [TW-1:0] tag;
      logic [DW-1:0] dat;
      logic [NW-1:0] num;
      logic [BW-1:0] bitcnt;
      logic [EW-1:0] errcnt;
      int            cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   en_cnt = 0;
   bit   last_en = 1'b0;

   // frame model state
   bit            mbits[$];
   bit            m_in = 1'b0;
   bit            m_first = 1'b0;
   logic [TW-1:0] m_tag = '0;
   int            m_bit = 0;
   int            m_err = 0;
   int            prev_bit = 0;
   int            prev_err = 0;
   int            last_cyc = 0;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // one output word per cycle: a word never leaves before the previous one
   task automatic push_word(input bit eop, input int n, input int cyc);
      exp_t e;
      e.dat = '0;
      for (int i = 0; i < n; i++) e.dat[i] = mbits.pop_front();
      e.num = NW'(n);
      e.sop = m_first;
      e.eop = eop;
      e.tag = m_tag;
      if (eop) begin
         prev_bit = m_bit;
`ifdef VIT_3BY4_BITPACK_ERRCNT_EN
         prev_err = m_err;
`else
         prev_err = 0;
`endif
      end
      e.bitcnt = BW'(prev_bit);
      e.errcnt = EW'(prev_err);
      e.cyc    = (cyc > last_cyc) ? cyc : last_cyc + 1;
      last_cyc = e.cyc;
      m_first  = 1'b0;
      sb.push_back(e);
   endtask

   task automatic model(input bit sop, input bit val, input bit eop, input logic [TW-1:0] tag,
                        input logic [2:0] dat, input logic [1:0] err, input int target);
      if (!val || !(sop || m_in)) return;
      if (sop) begin
         mbits.delete();
         m_in    = 1'b1;
         m_first = 1'b1;
         m_tag   = tag;
         m_bit   = 0;
         m_err   = 0;
      end
      for (int k = 0; k < 3; k++) mbits.push_back(dat[k]);
      m_bit = (m_bit + 3 > BMAX) ? BMAX : m_bit + 3;
      m_err = (m_err + int'(err) > EMAX) ? EMAX : m_err + int'(err);
      if (mbits.size() >= DW) push_word(eop && (mbits.size() == DW), DW, target);
      if (eop) begin
         if (mbits.size() > 0) push_word(1'b1, mbits.size(), target);
         m_in = 1'b0;
      end
   endtask

   // drive one enabled cycle; the capturing edge is the next enabled edge
   task automatic drive(input bit sop, input bit val, input bit eop, input logic [TW-1:0] tag,
                        input logic [2:0] dat, input logic [1:0] err);
      iclkena = 1'b1;
      isop    = sop;
      ival    = val;
      ieop    = eop;
      itag    = tag;
      idat    = dat;
      ibiterr = err;
      model(sop, val, eop, tag, dat, err, en_cnt + 1);
      @(posedge iclk);
      #1;
   endtask

   task automatic idle(input int n);
      isop = 1'b0;
      ival = 1'b0;
      ieop = 1'b0;
      repeat (n) begin
         @(posedge iclk);
         #1;
      end
   endtask

   // clock enable low with junk on the inputs: nothing may move
   task automatic gap(input int n);
      iclkena = 1'b0;
      isop    = 1'b0;
      ival    = 1'b1;
      ieop    = 1'b0;
      idat    = 3'b111;
      repeat (n) begin
         @(posedge iclk);
         #1;
      end
      iclkena = 1'b1;
   endtask

   // pat >= 0: constant symbol; -1: random; -2: symbol index
   task automatic frame(input logic [TW-1:0] tag, input int n, input logic [1:0] err, input int pat);
      logic [2:0] d;
      for (int i = 0; i < n; i++) begin
         if (pat >= 0)       d = 3'(pat);
         else if (pat == -1) d = 3'($urandom_range(7));
         else                d = 3'(i);
         drive(i == 0, 1'b1, i == n - 1, tag, d, err);
      end
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_oval"},    64'(oval),    64'd0);
      check({name, "_osop"},    64'(osop),    64'd0);
      check({name, "_oeop"},    64'(oeop),    64'd0);
      check({name, "_odat"},    64'(odat),    64'd0);
      check({name, "_onum"},    64'(onum),    64'd0);
      check({name, "_otag"},    64'(otag),    64'd0);
      check({name, "_obitcnt"}, 64'(obitcnt), 64'd0);
      check({name, "_oerrcnt"}, 64'(oerrcnt), 64'd0);
   endtask

   always @(posedge iclk) begin
      last_en <= iclkena;
      if (iclkena) en_cnt <= en_cnt + 1;
   end

   // scoreboard: every word produced after an enabled edge is popped and compared
   always @(negedge iclk) begin
      exp_t e;
      if (ireset_n && last_en && oval) begin
         check("word_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("cycle", 64'(en_cnt), 64'(e.cyc));
            check("osop",  64'(osop),   64'(e.sop));
            check("oeop",  64'(oeop),   64'(e.eop));
            check("otag",  64'(otag),   64'(e.tag));
            check("odat",  64'(odat),   64'(e.dat));
            check("onum",  64'(onum),   64'(e.num));
            check("obitcnt", 64'(obitcnt), 64'(e.bitcnt));
            check("oerrcnt", 64'(oerrcnt), 64'(e.errcnt));
         end
      end
   end

   initial begin
      ireset_n = 1'b0;
      iclkena  = 1'b1;
      isop     = 1'b0;
      ival     = 1'b0;
      ieop     = 1'b0;
      itag     = '0;
      idat     = '0;
      ibiterr  = '0;
      repeat (3) @(posedge iclk);
      #1;
      check_zero_outputs("reset");
      ireset_n = 1'b1;
      idle(2);

      // valid symbols before any sop are dropped
      drive(1'b0, 1'b1, 1'b0, 4'd1, 3'b111, 2'd1);
      drive(1'b0, 1'b1, 1'b0, 4'd1, 3'b101, 2'd1);
      drive(1'b0, 1'b1, 1'b1, 4'd1, 3'b011, 2'd1);
      idle(2);

      // 8 symbols -> 3 full words, tag 5, 24 bits
      frame(4'd5, 8, 2'd1, -2);
      idle(2);

      // 3 x 111 -> FF (no eop), then 01 with eop one cycle later
      frame(4'd3, 3, 2'd0, 7);
      idle(2);

      // tail frame followed immediately by a new frame with another tag
      frame(4'd2, 3, 2'd2, -1);
      frame(4'd7, 6, 2'd1, -1);
      idle(2);

      // single-symbol frame -> 05, onum 3, sop and eop together
      frame(4'd9, 1, 2'd3, 5);
      idle(2);

      // 20 corrected bits saturate a 4-bit error counter
      frame(4'd4, 20, 2'd1, -1);
      idle(2);

      // reset in the middle of a frame drops the partial word
      drive(1'b1, 1'b1, 1'b0, 4'd8, 3'b110, 2'd0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 4'd8, 3'(i + 1), 2'd0);
      check("pre_reset_drained", 64'(sb.size()), 64'd0);
      ival     = 1'b0;
      ireset_n = 1'b0;
      #1;
      check_zero_outputs("mid_reset");
      mbits.delete();
      m_in     = 1'b0;
      prev_bit = 0;
      prev_err = 0;
      @(posedge iclk);
      #1;
      ireset_n = 1'b1;
      idle(1);
      frame(4'd6, 1, 2'd1, 3);
      idle(3);

      // clock-enable gap mid-frame only delays the words
      drive(1'b1, 1'b1, 1'b0, 4'd10, 3'b001, 2'd1);
      drive(1'b0, 1'b1, 1'b0, 4'd10, 3'b010, 2'd0);
      drive(1'b0, 1'b1, 1'b0, 4'd10, 3'b111, 2'd1);
      gap(3);
      drive(1'b0, 1'b1, 1'b0, 4'd10, 3'b100, 2'd1);
      drive(1'b0, 1'b1, 1'b0, 4'd10, 3'b011, 2'd0);
      drive(1'b0, 1'b1, 1'b1, 4'd10, 3'b110, 2'd1);
      idle(2);

      // back-to-back random frames
      for (int f = 0; f < 6; f++) frame(4'(f + 11), 2 + (f * 3) % 9, 2'(f), -1);
      idle(5);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
